// File: rtl/fpaddsub_normround_pack.sv
// Back end of the 8-bit float add/sub path (1.3.4, bias 3): it normalizes the raw
// adder magnitude, rounds to nearest-even, packs the result and flags special inputs.
module fpaddsub_normround_pack (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       Sign,
    input  logic [2:0] Exp,
    input  logic [6:0] Sum,
    input  logic       Sticky,
    input  logic       EffSub,
    input  logic [4:0] InputExc,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] Result,
    output logic       Overflow,
    output logic       Underflow,
    output logic       Inexact,
    output logic       Invalid
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t     state_q, state_d;
    logic [6:0] m_q, m_d;
    logic [3:0] e_q, e_d;
    logic       s_q, s_d;
    logic       sign_q, sign_d;
    logic       effsub_q, effsub_d;
    logic [4:0] exc_q, exc_d;
    logic [7:0] result_q, result_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;
    logic       inx_q, inx_d;
    logic       inv_q, inv_d;

    // Rounding datapath, only consumed in ROUND
    logic       rnd_g, rnd_inc, rnd_hid, rnd_ovf, rnd_inx;
    logic [5:0] rnd_sum;
    logic [3:0] rnd_mant;
    logic [3:0] rnd_e;
    logic [2:0] rnd_expf;

    always_comb begin
        rnd_g    = m_q[0];
        rnd_inc  = rnd_g & (s_q | m_q[1]);
        rnd_sum  = {1'b0, m_q[5:1]} + {5'b0, rnd_inc};
        rnd_hid  = 1'b0;
        rnd_mant = 4'd0;
        rnd_e    = e_q;
        if (rnd_sum[5]) begin
            rnd_hid  = 1'b1;
            rnd_mant = 4'd0;
            rnd_e    = e_q + 4'd1;
        end else begin
            rnd_hid  = rnd_sum[4];
            rnd_mant = rnd_sum[3:0];
            // A subnormal that rounds up into the normal range lands on exponent 1
            rnd_e    = (rnd_sum[4] && (e_q == 4'd0)) ? 4'd1 : e_q;
        end
        rnd_expf = rnd_hid ? rnd_e[2:0] : 3'b000;
        rnd_ovf  = (rnd_e >= 4'd7);
        rnd_inx  = rnd_g | s_q;
    end

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        e_d      = e_q;
        s_d      = s_q;
        sign_d   = sign_q;
        effsub_d = effsub_q;
        exc_d    = exc_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;
        inv_d    = inv_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = NORM;
                    m_d      = Sum;
                    e_d      = {1'b0, Exp};
                    s_d      = Sticky;
                    sign_d   = Sign;
                    effsub_d = EffSub;
                    exc_d    = InputExc;
                end
            end
            NORM: begin
                if (exc_q[4]) begin
                    state_d = DONE;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    inx_d   = 1'b0;
                    inv_d   = 1'b0;
                    if (exc_q[3] | exc_q[2]) begin
                        result_d = 8'h78;
                    end else if (exc_q[1] & exc_q[0] & effsub_q) begin
                        result_d = 8'h78;
                        inv_d    = 1'b1;
                    end else begin
                        result_d = {sign_q, 3'b111, 4'b0000};
                    end
                end else if (m_q[6]) begin
                    m_d     = {1'b0, m_q[6:1]};
                    s_d     = s_q | m_q[0];
                    e_d     = e_q + 4'd1;
                    state_d = ROUND;
                end else if (m_q[5]) begin
                    state_d = ROUND;
                end else if ((m_q == 7'd0) && !s_q) begin
                    state_d  = DONE;
                    result_d = 8'h00;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    inx_d    = 1'b0;
                    inv_d    = 1'b0;
                end else if (e_q > 4'd1) begin
                    m_d = {m_q[5:0], 1'b0};
                    e_d = e_q - 4'd1;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                state_d = DONE;
                e_d     = rnd_e;
                inv_d   = 1'b0;
                if (rnd_ovf) begin
                    result_d = {sign_q, 3'b111, 4'b0000};
                    ovf_d    = 1'b1;
                    inx_d    = 1'b1;
                    unf_d    = 1'b0;
                end else begin
                    result_d = {sign_q, rnd_expf, rnd_mant};
                    ovf_d    = 1'b0;
                    inx_d    = rnd_inx;
                    unf_d    = rnd_inx & (rnd_expf == 3'b000);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            m_q      <= 7'd0;
            e_q      <= 4'd0;
            s_q      <= 1'b0;
            sign_q   <= 1'b0;
            effsub_q <= 1'b0;
            exc_q    <= 5'd0;
            result_q <= 8'h00;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            e_q      <= e_d;
            s_q      <= s_d;
            sign_q   <= sign_d;
            effsub_q <= effsub_d;
            exc_q    <= exc_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
            inv_q    <= inv_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Result    = result_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
    assign Inexact   = inx_q;
    assign Invalid   = inv_q;

endmodule

// File: tb/tb_fpaddsub_normround_pack.sv
// Directed bench for fpaddsub_normround_pack: hand-computed results, flags and
// latencies, plus backpressure and asynchronous reset in the middle of normalization.
module tb_fpaddsub_normround_pack;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       Sign;
    logic [2:0] Exp;
    logic [6:0] Sum;
    logic       Sticky;
    logic       EffSub;
    logic [4:0] InputExc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Result;
    logic       Overflow;
    logic       Underflow;
    logic       Inexact;
    logic       Invalid;

    int checks = 0;
    int errors = 0;

    fpaddsub_normround_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sign      (Sign),
        .Exp       (Exp),
        .Sum       (Sum),
        .Sticky    (Sticky),
        .EffSub    (EffSub),
        .InputExc  (InputExc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Overflow  (Overflow),
        .Underflow (Underflow),
        .Inexact   (Inexact),
        .Invalid   (Invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge. Flags are packed as {Overflow,Underflow,Inexact,Invalid}.
    task automatic op(input string tag, input logic sg, input logic [2:0] ex,
                      input logic [6:0] sm, input logic st, input logic es,
                      input logic [4:0] exc, input logic [7:0] exp_res,
                      input logic [3:0] exp_flags, input int exp_lat, input int hold);
        int lat;
        logic [7:0] held;
        chk({tag, ".in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        Sign = sg; Exp = ex; Sum = sm; Sticky = st; EffSub = es; InputExc = exc;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Garbage on the data bus must not disturb the transaction in flight
        Sign = ~sg; Exp = ~ex; Sum = ~sm; Sticky = ~st; EffSub = ~es; InputExc = ~exc;
        chk({tag, ".in_ready_busy"}, {31'd0, in_ready}, 32'd0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".result"}, {24'd0, Result}, {24'd0, exp_res});
        chk({tag, ".flags"}, {28'd0, Overflow, Underflow, Inexact, Invalid}, {28'd0, exp_flags});
        $display("op %s: result=%02h flags=%04b latency=%0d", tag, Result,
                 {Overflow, Underflow, Inexact, Invalid}, lat);
        held = exp_res;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk({tag, ".hold_result"}, {24'd0, Result}, {24'd0, held});
            chk({tag, ".hold_valid"}, {30'd0, out_valid, in_ready}, 32'd2);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".release"}, {30'd0, out_valid, in_ready}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        Sign = 1'b0; Exp = 3'd0; Sum = 7'd0; Sticky = 1'b0; EffSub = 1'b0; InputExc = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.valid_ready", {30'd0, out_valid, in_ready}, 32'd1);
        chk("reset.result", {24'd0, Result}, 32'h00);
        chk("reset.flags", {28'd0, Overflow, Underflow, Inexact, Invalid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //  tag           S     Exp   Sum         St    Eff   Exc        Res    OUXI     lat hold
        op("carry",       1'b0, 3'd3, 7'b1000000, 1'b0, 1'b0, 5'b00000, 8'h40, 4'b0000, 3, 4);
        op("cancel",      1'b0, 3'd5, 7'b0000100, 1'b0, 1'b1, 5'b00000, 8'h20, 4'b0000, 6, 0);
        op("tie_up",      1'b0, 3'd3, 7'b0100011, 1'b0, 1'b0, 5'b00000, 8'h32, 4'b0010, 3, 0);
        op("tie_down",    1'b0, 3'd3, 7'b0100001, 1'b0, 1'b0, 5'b00000, 8'h30, 4'b0010, 3, 0);
        op("overflow",    1'b1, 3'd6, 7'b1111111, 1'b1, 1'b0, 5'b00000, 8'hF0, 4'b1010, 3, 0);
        op("inf_m_inf",   1'b0, 3'd2, 7'b0100000, 1'b0, 1'b1, 5'b10011, 8'h78, 4'b0001, 2, 0);
        op("inf_p_inf",   1'b1, 3'd2, 7'b0100000, 1'b0, 1'b0, 5'b10011, 8'hF0, 4'b0000, 2, 0);
        op("nan_a",       1'b1, 3'd2, 7'b0100000, 1'b0, 1'b0, 5'b11000, 8'h78, 4'b0000, 2, 0);
        op("zero",        1'b1, 3'd4, 7'b0000000, 1'b0, 1'b1, 5'b00000, 8'h00, 4'b0000, 2, 0);
        op("sub_round1",  1'b0, 3'd1, 7'b0011111, 1'b0, 1'b0, 5'b00000, 8'h10, 4'b0010, 3, 0);
        op("sub_round0",  1'b0, 3'd0, 7'b0011111, 1'b0, 1'b0, 5'b00000, 8'h10, 4'b0010, 3, 0);
        op("subnormal",   1'b0, 3'd2, 7'b0000110, 1'b1, 1'b1, 5'b00000, 8'h06, 4'b0110, 4, 0);
        op("sticky_up",   1'b0, 3'd4, 7'b0101001, 1'b1, 1'b0, 5'b00000, 8'h45, 4'b0010, 3, 0);

        // Asynchronous reset while NORM is still shifting
        Sign = 1'b0; Exp = 3'd5; Sum = 7'b0000100; Sticky = 1'b0; EffSub = 1'b1; InputExc = 5'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midreset.valid_ready", {30'd0, out_valid, in_ready}, 32'd1);
        chk("midreset.result", {24'd0, Result}, 32'h00);
        chk("midreset.flags", {28'd0, Overflow, Underflow, Inexact, Invalid}, 32'd0);
        $display("op midreset: out_valid=%0b in_ready=%0b result=%02h", out_valid, in_ready, Result);
        @(negedge clk);
        rst_n = 1'b1;
        op("after_reset", 1'b0, 3'd5, 7'b0000100, 1'b0, 1'b1, 5'b00000, 8'h20, 4'b0000, 6, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpaddsub_normround_pack.md
FPADDSUB_NORMROUND_PACK -- requirements
Module: fpaddsub_normround_pack

Format: 8-bit float, sign [7], exponent [6:4] (bias 3), mantissa [3:0]; exponent 111 = Inf (mantissa 0) / NaN (mantissa non-zero). This block is the back end of the add/sub path: it normalizes and rounds the raw adder result, then packs it.

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with no parameters.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  upstream operand valid.
REQ-005 in_ready  output  1  block can accept; high only in IDLE.
REQ-006 Sign  input  1  result sign computed upstream.
REQ-007 Exp  input  3  pre-normalization exponent field.
REQ-008 Sum  input  7  raw magnitude {carry, hidden, m[3:0], guard}.
REQ-009 Sticky  input  1  OR of all bits shifted out during alignment.
REQ-010 EffSub  input  1  effective subtraction.
REQ-011 InputExc  input  5  {any, ANaN, BNaN, AInf, BInf}.
REQ-012 out_valid  output  1  Result valid.
REQ-013 out_ready  input  1  downstream accepts.
REQ-014 Result  output  8  packed result.
REQ-015 Overflow, Underflow, Inexact, Invalid  output  1 each  status flags.

Function
REQ-016 Accept SHALL occur on a clk edge with in_valid & in_ready; all inputs are captured and the FSM moves IDLE -> NORM.
REQ-017 FSM states SHALL be IDLE, NORM, ROUND, DONE; no other states.
REQ-018 Internal exponent E SHALL be 4 bits, zero-extended from Exp; internal M = Sum, with S = Sticky.
REQ-019 NORM with InputExc[4]=1 SHALL go to DONE with:
- Result 0x78 when ANaN|BNaN, or when AInf&BInf&EffSub (Invalid=1 only for this Inf-Inf case).
- otherwise {Sign,111,0000}.
- all other flags 0.
REQ-020 NORM with M[6]=1: M>>=1, S|=old M[0], E+=1, go ROUND, all in one cycle.
REQ-021 NORM with M[6:5]=01: go ROUND.
REQ-022 NORM with M=0 and S=0: go DONE with Result 0x00 and all flags 0.
REQ-023 NORM with M[6:5]=00, E>1: M<<=1, E-=1, remain in NORM; one shift per cycle.
REQ-024 NORM with M[6:5]=00, E<=1: stop shifting (subnormal) and go ROUND.
REQ-025 ROUND SHALL use round-to-nearest-even: G=M[0], L=M[1]; increment M[5:1] when G&(S|L).
- Increment carry into bit 6: E+=1 and mantissa becomes 0000.
REQ-026 Packing: exponent field = E[2:0] if M[5]=1, else 000; mantissa = M[4:1].
- A subnormal that rounds up to M[5]=1 SHALL pack exponent 001.
REQ-027 If E>=7 after rounding: Result={Sign,111,0000}, Overflow=1, Inexact=1.
REQ-028 Flag rules:
- Inexact = G|S (or overflow).
- Underflow = Inexact & packed exponent 000.
REQ-029 Latency SHALL be 2 cycles for exception and zero paths, and 3+n cycles for other results, where n = number of left shifts.
- Latency is measured from the accept edge to the edge after which out_valid=1.
REQ-030 In DONE, out_valid SHALL be 1, and Result and flags SHALL hold stable until out_ready=1.
REQ-031 DONE with out_ready=1 SHALL go to IDLE; in_ready rises the following cycle (no same-cycle re-accept).
REQ-032 in_valid and all data inputs SHALL be ignored outside IDLE.

Reset
REQ-033 rst_n low SHALL immediately force the following, regardless of state (including mid-NORM):
- state IDLE.
- out_valid=0, Result=0x00, all flags 0.
- in_ready=1.
- internal M, E, S cleared.
REQ-034 The first accept SHALL be possible on the first clk edge after rst_n deasserts.

Verification
REQ-035 Carry path: Sign=0, Exp=3, Sum=1000000, Sticky=0 -> Result 0x40, Inexact=0, out_valid after 3 cycles.
REQ-036 Cancellation: Exp=5, Sum=0000100, Sticky=0 -> 3 shifts, Result 0x20, latency 6.
REQ-037 Tie-to-even:
- Exp=3, Sum=0100011 -> 0x32, Inexact=1.
- Exp=3, Sum=0100001 -> 0x30, Inexact=1.
REQ-038 Overflow: Sign=1, Exp=6, Sum=1111111, Sticky=1 -> 0xF0, Overflow=1, Inexact=1.
REQ-039 Exceptions:
- InputExc=10011, EffSub=1 -> 0x78, Invalid=1.
- InputExc=10011, EffSub=0, Sign=1 -> 0xF0, Invalid=0.
- InputExc=11000 -> 0x78, Invalid=0.
REQ-040 Backpressure and reset:
- out_ready low for 4 cycles in DONE -> Result stable and in_ready=0.
- rst_n pulsed low mid-NORM -> out_valid=0 and in_ready=1 immediately, and a new accept completes normally.
